// File: rtl/stream_buffer_array_if.sv
// AXI3 read-channel bundle (AR + R) shared by the stream buffer and the bus.
interface axi3_rd_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/stream_buffer_array.sv
// Multi-entry prefetch stream buffer: holds NUM_SB prefetched lines tagged by
// line label, fetches one line per AXI3 INCR burst, LRU victim selection.
// Optional macro STREAM_BUFFER_AUTO_NEXT_EN chains a prefetch of label+1
// whenever a line is consumed while the fetch engine is idle.
module stream_buffer_array #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_SB      = 4,
    parameter int unsigned ARID        = 2,
    parameter int unsigned PHYS_WIDTH  = 32,
    parameter int unsigned LABEL_WIDTH = PHYS_WIDTH - $clog2(LINE_WIDTH / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pf_req,
    input  logic [LABEL_WIDTH-1:0] pf_label,
    output logic                   pf_rdy,
    input  logic                   inv,
    input  logic                   lk_req,
    input  logic [LABEL_WIDTH-1:0] lk_label,
    output logic                   lk_hit,
    output logic                   lk_pending,
    output logic [LINE_WIDTH-1:0]  lk_data,
    axi3_rd_if.master              axi3_rd
);
    localparam int unsigned WORDS = LINE_WIDTH / DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_SB);
    localparam int unsigned OFF_W = PHYS_WIDTH - LABEL_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_AR,
        S_RECV,
        S_FLUSH_AR,
        S_FLUSH_RECV
    } state_t;

    state_t                            state;
    logic [CNT_W-1:0]                  burst_cnt;
    logic                              burst_full;
    logic [IDX_W-1:0]                  tgt;

    logic [NUM_SB-1:0]                 ent_valid;
    logic [LABEL_WIDTH-1:0]            ent_label [NUM_SB];
    logic [WORDS-1:0]                  ent_vld   [NUM_SB];
    logic [WORDS-1:0][DATA_WIDTH-1:0]  ent_data  [NUM_SB];
    logic [IDX_W-1:0]                  ent_age   [NUM_SB];

    logic [IDX_W-1:0]                  lk_idx;
    logic                              consume;
    logic                              ext_req;
    logic                              auto_req;
    logic [LABEL_WIDTH-1:0]            req_label;
    logic                              dup;
    logic                              alloc;
    logic [NUM_SB-1:0]                 free;
    logic                              free_found;
    logic [IDX_W-1:0]                  victim;
    logic                              touch_en;
    logic [IDX_W-1:0]                  touch_idx;
    logic                              beat_acc;
    logic                              beat_wr;
    logic                              unused_r;

    assign axi3_rd.arlen   = 4'(WORDS - 1);
    assign axi3_rd.arsize  = 3'b010;
    assign axi3_rd.arburst = 2'b01;
    assign axi3_rd.arid    = $bits(axi3_rd.arid)'(ARID);
    assign unused_r        = ^{axi3_rd.rid, axi3_rd.rresp};

    // Label lookup against registered entry state; labels are unique among valid entries.
    always_comb begin
        lk_hit     = 1'b0;
        lk_pending = 1'b0;
        lk_data    = '0;
        lk_idx     = '0;
        for (int i = 0; i < NUM_SB; i++) begin
            if (ent_valid[i] && ent_label[i] == lk_label) begin
                lk_hit     = &ent_vld[i];
                lk_pending = ~&ent_vld[i];
                lk_data    = ent_data[i];
                lk_idx     = IDX_W'(i);
            end
        end
    end

    // Request source, duplicate filter against pre-edge state, and allocation decision.
    always_comb begin
        consume  = lk_req & lk_hit;
        ext_req  = (state == S_IDLE) & pf_req & ~inv;
`ifdef STREAM_BUFFER_AUTO_NEXT_EN
        auto_req  = (state == S_IDLE) & consume & ~pf_req & ~inv;
        req_label = pf_req ? pf_label : lk_label + LABEL_WIDTH'(1);
`else
        auto_req  = 1'b0;
        req_label = pf_label;
`endif
        dup = 1'b0;
        for (int i = 0; i < NUM_SB; i++) begin
            if (ent_valid[i] && ent_label[i] == req_label) begin
                dup = 1'b1;
            end
        end
        alloc = (ext_req | auto_req) & ~dup;
    end

    // Victim: lowest-index free entry (a line consumed this cycle counts as free), else oldest.
    always_comb begin
        free = ~ent_valid;
        if (consume) begin
            free[lk_idx] = 1'b1;
        end
        victim     = '0;
        free_found = 1'b0;
        for (int i = NUM_SB - 1; i >= 0; i--) begin
            if (free[i]) begin
                victim     = IDX_W'(i);
                free_found = 1'b1;
            end
        end
        if (!free_found) begin
            for (int i = 0; i < NUM_SB; i++) begin
                if (ent_age[i] == IDX_W'(NUM_SB - 1)) begin
                    victim = IDX_W'(i);
                end
            end
        end
        touch_en  = alloc | consume;
        touch_idx = alloc ? victim : lk_idx;
        beat_acc  = axi3_rd.rvalid & axi3_rd.rready;
        beat_wr   = (state == S_RECV) & beat_acc & ~burst_full;
    end

    // Entry array: LRU ages, allocation, consume, beat writes; invalidate wins last.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            for (int i = 0; i < NUM_SB; i++) begin
                ent_label[i] <= '0;
                ent_vld[i]   <= '0;
                ent_data[i]  <= '0;
                ent_age[i]   <= IDX_W'(i);
            end
        end else begin
            if (touch_en) begin
                for (int i = 0; i < NUM_SB; i++) begin
                    if (IDX_W'(i) == touch_idx) begin
                        ent_age[i] <= '0;
                    end else if (ent_age[i] < ent_age[touch_idx]) begin
                        ent_age[i] <= ent_age[i] + IDX_W'(1);
                    end
                end
            end
            if (consume) begin
                ent_valid[lk_idx] <= 1'b0;
            end
            if (alloc) begin
                ent_valid[victim] <= 1'b1;
                ent_label[victim] <= req_label;
                ent_vld[victim]   <= '0;
            end
            if (beat_wr) begin
                ent_data[tgt][burst_cnt] <= axi3_rd.rdata;
                ent_vld[tgt][burst_cnt]  <= 1'b1;
            end
            if (inv) begin
                ent_valid <= '0;
                for (int i = 0; i < NUM_SB; i++) begin
                    ent_vld[i] <= '0;
                end
            end
        end
    end

    // Fetch engine: one burst outstanding; flush states drain an AR/R already committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pf_rdy          <= 1'b1;
            axi3_rd.arvalid <= 1'b0;
            axi3_rd.araddr  <= '0;
            axi3_rd.rready  <= 1'b0;
            burst_cnt       <= '0;
            burst_full      <= 1'b0;
            tgt             <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (alloc) begin
                        tgt             <= victim;
                        axi3_rd.araddr  <= {req_label, OFF_W'(0)};
                        axi3_rd.arvalid <= 1'b1;
                        pf_rdy          <= 1'b0;
                        state           <= S_WAIT_AR;
                    end
                end
                S_WAIT_AR: begin
                    if (axi3_rd.arready) begin
                        axi3_rd.arvalid <= 1'b0;
                        axi3_rd.rready  <= 1'b1;
                        burst_cnt       <= '0;
                        burst_full      <= 1'b0;
                        state           <= inv ? S_FLUSH_RECV : S_RECV;
                    end else if (inv) begin
                        state <= S_FLUSH_AR;
                    end
                end
                S_RECV: begin
                    if (beat_wr) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                        if (burst_cnt == CNT_W'(WORDS - 1)) begin
                            burst_full <= 1'b1;
                        end
                    end
                    if (beat_acc && axi3_rd.rlast) begin
                        axi3_rd.rready <= 1'b0;
                        pf_rdy         <= 1'b1;
                        state          <= S_IDLE;
                    end else if (inv) begin
                        state <= S_FLUSH_RECV;
                    end
                end
                S_FLUSH_AR: begin
                    if (axi3_rd.arready) begin
                        axi3_rd.arvalid <= 1'b0;
                        axi3_rd.rready  <= 1'b1;
                        state           <= S_FLUSH_RECV;
                    end
                end
                S_FLUSH_RECV: begin
                    if (beat_acc && axi3_rd.rlast) begin
                        axi3_rd.rready <= 1'b0;
                        pf_rdy         <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/stream_buffer_array.md
# stream_buffer_array

Multi-entry prefetch stream buffer between a cache's miss path and the shared AXI3 read bus. It holds up to NUM_SB prefetched cache lines, each tagged by a line label, and fetches one line at a time with an INCR burst. The cache looks a label up combinationally, and a complete hit hands over the whole line. LRU replacement chooses the victim entry, and an optional mode chains the next sequential line automatically.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- DATA_WIDTH, 32, AXI beat width in bits
- NUM_SB, 4, number of line entries (power of 2, ≥2)
- ARID, 2, AXI read ID driven on every request
- LABEL_WIDTH, derived, $bits(phys_t) − log2(LINE_WIDTH/8) (27 at defaults)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pf_req  in  1  prefetch request, sampled only while pf_rdy=1
- pf_label  in  LABEL_WIDTH  line label to prefetch
- pf_rdy  out  1  engine idle, able to accept pf_req
- inv  in  1  invalidate all entries and flush any in-flight burst
- lk_req  in  1  lookup and consume
- lk_label  in  LABEL_WIDTH  lookup label
- lk_hit  out  1  a valid entry matches lk_label and all of its words are present (combinational)
- lk_pending  out  1  a valid entry matches lk_label and is still filling (combinational)
- lk_data  out  LINE_WIDTH  line of the matching entry; word i is at bits [i·DATA_WIDTH +: DATA_WIDTH]
- axi3_rd_if  master  —  AXI3 read channel (AR and R)

## Operation
- Per entry state: valid, label, data, per-word vld bits (WORDS = LINE_WIDTH/DATA_WIDTH), LRU age (log2 NUM_SB bits).
- Fetch engine FSM, one burst outstanding at a time:
  - IDLE: pf_rdy=1. On pf_req & ~inv & no duplicate, allocate the victim, go to WAIT_AR.
  - WAIT_AR: arvalid=1. On arready, go to RECV, or to FLUSH_RECV if inv is high. Otherwise, inv high goes to FLUSH_AR.
  - RECV: rready=1. Each rvalid beat writes word burst_cnt of the target entry and sets its vld bit. rvalid & rlast goes to IDLE. Otherwise, inv high goes to FLUSH_RECV.
  - FLUSH_AR: arvalid stays 1 (AR is never retracted). On arready, go to FLUSH_RECV.
  - FLUSH_RECV: rready=1, data discarded. rvalid & rlast goes to IDLE.
- AR fields:
  - araddr = {label, zero byte offset}
  - arlen = WORDS−1 (7 at defaults)
  - arsize = 3'b010
  - arburst = 2'b01
  - arid = ARID
- Duplicate rule: if pf_label matches any valid entry (complete or filling), the request is dropped. No AXI traffic, state stays IDLE.
- Allocation:
  - Victim is the lowest-index invalid entry; if none is invalid, the entry with the oldest age.
  - On allocation the entry becomes valid with the new label, vld bits cleared, age made youngest.
- Consume: lk_req & lk_hit invalidates the matching entry at the next edge and ages the remaining entries. lk_data is valid in the same cycle.
- The entry being filled is never a victim; this is guaranteed because pf_rdy=0 while a fill is in progress.
- inv: all valid and vld bits clear at the next edge, and lk_hit/lk_pending read 0 from then on. pf_rdy stays 0 until the flush reaches IDLE. pf_req in the same cycle as inv is ignored.
- Simultaneous consume and pf_req of the same label: counted as a duplicate against the pre-edge state, so the request is dropped.
- burst_cnt is log2(WORDS) bits, cleared when the AR handshake completes, and increments per accepted beat.
- A beat arriving after all WORDS words have been received without rlast is ignored; rready stays 1 until rlast.

## Timing
- Reset values: state IDLE, all entries invalid, age = index, burst_cnt=0. Outputs: pf_rdy=1, arvalid=0, rready=0, lk_hit=0, lk_pending=0, lk_data=0.
- pf_req accepted at edge t gives arvalid=1 from cycle t+1.
- A beat accepted at edge t sets its vld bit at t+1. After the rlast beat, lk_hit can assert from t+1 and pf_rdy=1 from t+1.
- Minimum request-to-hit latency: 2 + arready wait + WORDS beats.
- lk_hit, lk_pending and lk_data are purely combinational from lk_label and the registered entry state.
- rst mid-burst returns to IDLE immediately, with no drain. The interconnect is reset in the same cycle.

## Configuration
- STREAM_BUFFER_AUTO_NEXT_EN defined:
  - When a consume (lk_req & lk_hit) occurs in a cycle where the engine is IDLE, there is no external pf_req and inv=0, an internal request for lk_label+1 is issued (wraps modulo 2^LABEL_WIDTH).
  - That request follows the normal duplicate and victim rules.
  - If the engine is busy or pf_req is present, the chained request is dropped.
- Undefined: no internal requests; prefetch is driven only by pf_req.

## Test plan
- Reset, then pf_req label=0x100 with arready the next cycle and 8 beats D0..D7 with rlast on beat 7:
  - AR araddr=0x2000, arlen=7.
  - lk_pending=1 during the fill.
  - lk_label=0x100 gives lk_hit=1 the cycle after rlast, with lk_data[31:0]=D0.
- Fill labels 1,2,3,4, consume label 2, then prefetch label 5: label 5 occupies label 2's slot. Prefetch label 6 with no invalid entry: evicts label 1 (oldest).
- pf_req for a label already resident or filling: no arvalid, pf_rdy stays 1.
- inv pulses during WAIT_AR:
  - arvalid is held until arready.
  - All 8 beats are drained with rready=1, and pf_rdy returns only after rlast.
  - lk_hit=0 for every previous label.
- inv pulses mid-RECV at beat 3: beats 4–7 are discarded and no entry becomes valid.
- With STREAM_BUFFER_AUTO_NEXT_EN, consuming label 0x7FFFFFF while idle issues araddr for label 0 (wrap). Without the macro, no AR is issued.
